// File: rtl/run_ctrl_if.sv
`default_nettype none
// ============================================================================
// run_ctrl_if : key/switch/halt inputs and CPU control/status outputs of the
//               run/step controller.  Revision 1.0
// ============================================================================
interface run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [1:0]       KEY_P;
    logic [9:0]       SW;
    logic             HALT_REQ;
    logic             CPU_EN;
    logic             CPU_RST;
    logic [2:0]       STATE;
    logic             HALTED;
    logic [CNT_W-1:0] CYC_CNT;

    modport master (
        output KEY_P, SW, HALT_REQ,
        input  CPU_EN, CPU_RST, STATE, HALTED, CYC_CNT
    );

    modport slave (
        input  KEY_P, SW, HALT_REQ,
        output CPU_EN, CPU_RST, STATE, HALTED, CYC_CNT
    );
endinterface
`default_nettype wire

// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
// run_ctrl : run/step controller producing the MIPS core clock-enable/reset
//            for single-step, burst, free-run and run-until-halt execution.
//            Revision 1.0
// ============================================================================
module run_ctrl #(
    parameter int RST_CYC = 4,
    parameter int CNT_W   = 32
) (
    input  logic     CLK,
    input  logic     RST,
    run_ctrl_if.slave bus
);
    localparam int            RW       = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RW-1:0] RST_LOAD = RW'(RST_CYC - 1);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_IDLE  = 3'd1,
        S_STEP  = 3'd2,
        S_BURST = 3'd3,
        S_RUN   = 3'd4,
        S_CRST  = 3'd5
    } state_t;

    state_t           state, state_nx;
    logic [RW-1:0]    rst_cnt, rst_cnt_nx;
    logic [7:0]       burst_cnt, burst_cnt_nx;
    logic [1:0]       mode, mode_nx;
    logic             halted, halted_nx;
    logic             cyc_clr;
    logic             cpu_en, cpu_en_nx;
    logic             cpu_rst, cpu_rst_nx;
    logic [CNT_W-1:0] cyc_cnt;

    logic go, stop, halt_hit;

    assign go   = bus.KEY_P[0];
    assign stop = bus.KEY_P[1];
    // Free-run (10) is the only run mode that ignores the core's halt request.
    assign halt_hit = bus.HALT_REQ && (mode != 2'b10);

    always_comb begin
        state_nx     = state;
        rst_cnt_nx   = rst_cnt;
        burst_cnt_nx = burst_cnt;
        mode_nx      = mode;
        halted_nx    = halted;
        cyc_clr      = 1'b0;
        case (state)
            S_INIT, S_CRST: begin
                if (rst_cnt == '0)
                    state_nx = S_IDLE;
                else
                    rst_cnt_nx = rst_cnt - 1'b1;
            end
            S_IDLE: begin
                if (stop) begin
                    state_nx   = S_CRST;
                    rst_cnt_nx = RST_LOAD;
                    halted_nx  = 1'b0;
                    cyc_clr    = 1'b1;
                end else if (go && !(bus.SW[9:8] == 2'b01 && bus.SW[7:0] == 8'd0)) begin
                    mode_nx      = bus.SW[9:8];
                    burst_cnt_nx = bus.SW[7:0];
                    halted_nx    = 1'b0;
                    case (bus.SW[9:8])
                        2'b00:   state_nx = S_STEP;
                        2'b01:   state_nx = S_BURST;
                        default: state_nx = S_RUN;
                    endcase
                end
            end
            S_STEP: begin
                state_nx = S_IDLE;
            end
            S_BURST: begin
                burst_cnt_nx = burst_cnt - 8'd1;
                if (halt_hit)
                    halted_nx = 1'b1;
                if (stop || halt_hit || burst_cnt == 8'd1)
                    state_nx = S_IDLE;
            end
            S_RUN: begin
                if (halt_hit)
                    halted_nx = 1'b1;
                if (stop || halt_hit)
                    state_nx = S_IDLE;
            end
            default: begin
                state_nx   = S_INIT;
                rst_cnt_nx = RST_LOAD;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // change in the same cycle the state does.
    assign cpu_en_nx  = (state_nx == S_STEP) || (state_nx == S_BURST) || (state_nx == S_RUN);
    assign cpu_rst_nx = (state_nx == S_INIT) || (state_nx == S_CRST);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= S_INIT;
            rst_cnt   <= RST_LOAD;
            burst_cnt <= 8'd0;
            mode      <= 2'b00;
            halted    <= 1'b0;
            cpu_en    <= 1'b0;
            cpu_rst   <= 1'b1;
            cyc_cnt   <= '0;
        end else begin
            state     <= state_nx;
            rst_cnt   <= rst_cnt_nx;
            burst_cnt <= burst_cnt_nx;
            mode      <= mode_nx;
            halted    <= halted_nx;
            cpu_en    <= cpu_en_nx;
            cpu_rst   <= cpu_rst_nx;
            if (cyc_clr)
                cyc_cnt <= '0;
            else if (cpu_en)
                cyc_cnt <= cyc_cnt + 1'b1;
        end
    end

    assign bus.CPU_EN  = cpu_en;
    assign bus.CPU_RST = cpu_rst;
    assign bus.STATE   = state;
    assign bus.HALTED  = halted;
    assign bus.CYC_CNT = cyc_cnt;
endmodule
`default_nettype wire

// File: tb/tb_run_ctrl.sv
`default_nettype none
// ============================================================================
// tb_run_ctrl : directed scenarios plus randomized key/switch/halt stimulus,
//               checked every cycle against a behavioural model.  Revision 1.0
// ============================================================================
module tb_run_ctrl;
    localparam int RST_CYC = 4;
    localparam int CNT_W   = 32;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    run_ctrl_if #(.CNT_W(CNT_W)) bus();

    run_ctrl #(.RST_CYC(RST_CYC), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: remaining CPU-reset cycles, remaining enabled cycles (-1 = unbounded).
    int               m_rst_left = RST_CYC;
    bit               m_crst     = 1'b0;
    int               m_en_left  = 0;
    int               m_kind     = 1;
    bit               m_soh      = 1'b0;
    bit               m_halted   = 1'b0;
    logic [CNT_W-1:0] m_cnt      = '0;

    always @(posedge CLK) begin : model
        bit go, stp, hit;
        go  = bus.KEY_P[0];
        stp = bus.KEY_P[1];
        if (!RST) begin
            m_rst_left = RST_CYC;
            m_crst     = 1'b0;
            m_en_left  = 0;
            m_kind     = 1;
            m_soh      = 1'b0;
            m_halted   = 1'b0;
            m_cnt      = '0;
        end else begin
            if (m_en_left != 0)
                m_cnt = m_cnt + 1'b1;
            if (m_rst_left > 0) begin
                m_rst_left--;
            end else if (m_en_left == 0) begin
                if (stp) begin
                    m_rst_left = RST_CYC;
                    m_crst     = 1'b1;
                    m_cnt      = '0;
                    m_halted   = 1'b0;
                end else if (go) begin
                    case (bus.SW[9:8])
                        2'b00: begin
                            m_en_left = 1; m_kind = 2; m_soh = 1'b0; m_halted = 1'b0;
                        end
                        2'b01: begin
                            if (bus.SW[7:0] != 8'd0) begin
                                m_en_left = int'(bus.SW[7:0]); m_kind = 3; m_soh = 1'b1; m_halted = 1'b0;
                            end
                        end
                        default: begin
                            m_en_left = -1; m_kind = 4; m_soh = bus.SW[8]; m_halted = 1'b0;
                        end
                    endcase
                end
            end else begin
                hit = bus.HALT_REQ && m_soh;
                if (hit)
                    m_halted = 1'b1;
                if (stp || hit || m_en_left == 1)
                    m_en_left = 0;
                else if (m_en_left > 0)
                    m_en_left--;
            end
        end
    end

    function automatic int exp_state();
        if (m_rst_left > 0)
            return m_crst ? 5 : 0;
        else if (m_en_left != 0)
            return m_kind;
        else
            return 1;
    endfunction

    always @(negedge CLK) begin : compare
        check("CPU_EN",  64'(bus.CPU_EN),  64'(m_en_left != 0));
        check("CPU_RST", 64'(bus.CPU_RST), 64'(m_rst_left > 0));
        check("STATE",   64'(bus.STATE),   64'(exp_state()));
        check("HALTED",  64'(bus.HALTED),  64'(m_halted));
        check("CYC_CNT", 64'(bus.CYC_CNT), 64'(m_cnt));
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic key(input logic [1:0] k);
        bus.KEY_P = k;
        tick();
        bus.KEY_P = 2'b00;
    endtask

    task automatic count(input int n, output int en_c, output int rst_c);
        en_c  = 0;
        rst_c = 0;
        repeat (n) begin
            @(negedge CLK);
            if (bus.CPU_EN)  en_c++;
            if (bus.CPU_RST) rst_c++;
            tick();
        end
    endtask

    initial begin : stim
        int e, r, et;
        bus.KEY_P    = 2'b00;
        bus.SW       = 10'd0;
        bus.HALT_REQ = 1'b0;
        RST          = 1'b0;

        repeat (3) tick();
        RST = 1'b1;
        count(8, e, r);
        check("t1_rst_cycles", 64'(r), 64'd4);
        check("t1_en_cycles",  64'(e), 64'd0);
        check("t1_state",      64'(bus.STATE), 64'd1);
        check("t1_cyc",        64'(bus.CYC_CNT), 64'd0);

        bus.SW = 10'b00_00000000;
        et = 0;
        repeat (3) begin
            key(2'b01);
            count(4, e, r);
            et += e;
        end
        check("t2_step_pulses", 64'(et), 64'd3);
        check("t2_cyc",         64'(bus.CYC_CNT), 64'd3);

        bus.SW = 10'b01_00000101;
        key(2'b01);
        count(10, e, r);
        check("t3_burst_len", 64'(e), 64'd5);
        check("t3_cyc",       64'(bus.CYC_CNT), 64'd8);
        bus.SW = 10'b01_00000000;
        key(2'b01);
        count(5, e, r);
        check("t3_burst0_en",    64'(e), 64'd0);
        check("t3_burst0_state", 64'(bus.STATE), 64'd1);

        bus.SW = 10'b11_00000000;
        key(2'b01);
        count(20, e, r);
        bus.HALT_REQ = 1'b1;
        count(1, et, r);
        bus.HALT_REQ = 1'b0;
        e += et;
        count(3, et, r);
        check("t4_halt_en",      64'(e), 64'd21);
        check("t4_after_halt",   64'(et), 64'd0);
        check("t4_halted",       64'(bus.HALTED), 64'd1);
        check("t4_cyc",          64'(bus.CYC_CNT), 64'd29);
        check("t4_model_cyc",    64'(m_cnt), 64'd29);

        bus.SW = 10'b10_00000000;
        key(2'b01);
        count(5, e, r);
        bus.HALT_REQ = 1'b1;
        count(3, e, r);
        bus.HALT_REQ = 1'b0;
        count(2, e, r);
        check("t4_free_state",  64'(bus.STATE), 64'd4);
        check("t4_free_halted", 64'(bus.HALTED), 64'd0);
        key(2'b10);
        count(3, e, r);
        check("t4_stop_en",     64'(e), 64'd0);
        check("t4_stop_state",  64'(bus.STATE), 64'd1);
        check("t4_stop_rst",    64'(r), 64'd0);

        key(2'b01);
        count(4, e, r);
        key(2'b11);
        count(2, e, r);
        check("t5_gostop_en",    64'(e), 64'd0);
        check("t5_gostop_state", 64'(bus.STATE), 64'd1);

        bus.SW = 10'b01_00010000;
        key(2'b01);
        count(3, e, r);
        bus.HALT_REQ = 1'b1;
        count(1, e, r);
        bus.HALT_REQ = 1'b0;
        count(3, e, r);
        check("t5_burst_halted", 64'(bus.HALTED), 64'd1);
        check("t5_model_halted", 64'(m_halted), 64'd1);
        key(2'b10);
        count(8, e, r);
        check("t5_crst_cycles", 64'(r), 64'd4);
        check("t5_crst_en",     64'(e), 64'd0);
        check("t5_crst_cyc",    64'(bus.CYC_CNT), 64'd0);
        check("t5_crst_halted", 64'(bus.HALTED), 64'd0);

        bus.SW = 10'b01_00001000;
        key(2'b01);
        count(2, e, r);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        check("t6_state",   64'(bus.STATE), 64'd0);
        check("t6_en",      64'(bus.CPU_EN), 64'd0);
        check("t6_rst",     64'(bus.CPU_RST), 64'd1);
        check("t6_cyc",     64'(bus.CYC_CNT), 64'd0);
        count(8, e, r);
        check("t6_rst_cycles", 64'(r), 64'd4);
        check("t6_en_cycles",  64'(e), 64'd0);

        repeat (4000) begin
            int k;
            k = int'($urandom_range(0, 99));
            bus.KEY_P = (k < 6) ? 2'b01 : (k < 9) ? 2'b10 : (k < 10) ? 2'b11 : 2'b00;
            if ($urandom_range(0, 19) == 0) begin
                bus.SW[9:8] = 2'($urandom_range(0, 3));
                bus.SW[7:0] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 12))
                                                           : 8'($urandom_range(0, 255));
            end
            bus.HALT_REQ = ($urandom_range(0, 29) == 0);
            RST = ($urandom_range(0, 299) != 0);
            tick();
        end
        bus.KEY_P = 2'b00;
        RST = 1'b1;
        count(2, e, r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
